// File: rtl/fetch_controller_pkg.sv
// Shared CPU front-end definitions: data/address widths, fetch state
// encoding and the opcode bit that marks a two-byte instruction.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Opcode bit index; a 1 here means an immediate byte follows the opcode.
    // The decoder uses the same definition to know an operand is present.
    localparam int LONG_BIT = 7;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_OPERAND = 3'd2,
        ST_VALID   = 3'd3,
        ST_HALTED  = 3'd4
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_controller_if.sv
// Bus between the fetch controller, instruction memory, decode and execute.
// master = fetch controller side, slave = the surrounding pipeline.
interface fetch_controller_if
    import cpu_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
) ();

    // From memory / decode / execute
    logic [DW-1:0] instr_byte;
    logic          stall;
    logic          halt;
    logic          pc_load;
    logic [AW-1:0] pc_target;
    logic          instr_ack;

    // From the fetch controller
    logic [AW-1:0] address;
    logic          memread;
    logic          irwrite;
    logic [DW-1:0] operand;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          halted;

    modport master (
        input  instr_byte, stall, halt, pc_load, pc_target, instr_ack,
        output address, memread, irwrite, operand, ir_pc, ir_valid, halted
    );

    modport slave (
        output instr_byte, stall, halt, pc_load, pc_target, instr_ack,
        input  address, memread, irwrite, operand, ir_pc, ir_valid, halted
    );

endinterface : fetch_controller_if

// File: rtl/fetch_controller_program_counter.sv
// Program counter register: synchronous reset, load of a redirect target,
// or increment (wrapping modulo 2^ADDR_W), otherwise hold.
module program_counter
    import cpu_pkg::*;
#(
    parameter int                 PC_W     = ADDR_W,
    parameter logic [PC_W-1:0]    RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_target,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    // PC update: load wins over increment; natural overflow gives the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_W'(1);
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule : program_counter

// File: rtl/fetch_controller.sv
// Fetch sequencer of the 8-bit multi-cycle CPU. Owns the PC, walks the
// IDLE/FETCH/OPERAND/VALID/HALTED FSM, captures the immediate byte of
// two-byte instructions and hands complete instructions to decode.
module fetch_controller
    import cpu_pkg::*;
#(
    parameter int                  ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                  DATA_W   = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0]   RESET_PC = 8'h00,
    parameter int                  LONG_BIT = cpu_pkg::LONG_BIT
) (
    input  logic               clk,
    input  logic               rst,
    fetch_controller_if.master bus
);

    fetch_state_e      r_state;
    fetch_state_e      w_next_state;

    logic              w_memread;
    logic              w_irwrite;
    logic              w_pc_inc;
    logic              w_pc_load;
    logic              w_cap_ir_pc;
    logic              w_cap_operand;
    logic [ADDR_W-1:0] w_pc;

    logic [ADDR_W-1:0] r_ir_pc;
    logic [DATA_W-1:0] r_operand;
    logic              r_ir_valid;
    logic              r_halted;

    program_counter #(
        .PC_W     (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_pc_load),
        .i_target (bus.pc_target),
        .i_inc    (w_pc_inc),
        .o_pc     (w_pc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and strobes. Priority: rst > halt > pc_load > stall > normal.
    // Memory strobes only come from the normal path, so halt, redirect and
    // stall all suppress them and a half-fetched instruction is dropped.
    always_comb begin
        w_next_state  = r_state;
        w_memread     = 1'b0;
        w_irwrite     = 1'b0;
        w_pc_inc      = 1'b0;
        w_pc_load     = 1'b0;
        w_cap_ir_pc   = 1'b0;
        w_cap_operand = 1'b0;

        if (rst) begin
            w_next_state = ST_IDLE;
        end else if (r_state == ST_HALTED) begin
            w_next_state = ST_HALTED;
        end else if (bus.halt) begin
            w_next_state = ST_HALTED;
        end else if (bus.pc_load) begin
            w_next_state = ST_FETCH;
            w_pc_load    = 1'b1;
        end else if (bus.stall) begin
            w_next_state = r_state;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_FETCH;
                end
                ST_FETCH: begin
                    w_memread   = 1'b1;
                    w_irwrite   = 1'b1;
                    w_cap_ir_pc = 1'b1;
                    w_pc_inc    = 1'b1;
                    if (bus.instr_byte[LONG_BIT]) begin
                        w_next_state = ST_OPERAND;
                    end else begin
                        w_next_state = ST_VALID;
                    end
                end
                ST_OPERAND: begin
                    w_memread     = 1'b1;
                    w_cap_operand = 1'b1;
                    w_pc_inc      = 1'b1;
                    w_next_state  = ST_VALID;
                end
                ST_VALID: begin
                    if (bus.instr_ack) begin
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_VALID;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Instruction bookkeeping; ir_valid/halted track the state being entered
    // so they line up exactly with VALID/HALTED. Short opcodes leave operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir_pc    <= '0;
            r_operand  <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            if (w_cap_ir_pc) begin
                r_ir_pc <= w_pc;
            end
            if (w_cap_operand) begin
                r_operand <= bus.instr_byte;
            end
            r_ir_valid <= (w_next_state == ST_VALID);
            r_halted   <= (w_next_state == ST_HALTED);
        end
    end

    assign bus.address  = w_pc;
    assign bus.memread  = w_memread;
    assign bus.irwrite  = w_irwrite;
    assign bus.operand  = r_operand;
    assign bus.ir_pc    = r_ir_pc;
    assign bus.ir_valid = r_ir_valid;
    assign bus.halted   = r_halted;

endmodule : fetch_controller

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller. Stimulus pushes the expected
// instruction (ir_pc, operand, pc after fetch) into a queue; a monitor pops
// and compares each time ir_valid rises. Cycle-level strobes are checked inline.
module tb_fetch_controller;

    typedef struct packed {
        logic [7:0] ir_pc;
        logic [7:0] operand;
        logic [7:0] pc;
    } exp_t;

    logic clk;
    logic rst;
    logic [7:0] mem [0:255];
    exp_t sb_q [$];
    int checks;
    int failures;

    fetch_controller_if bus ();

    assign bus.instr_byte = mem[bus.address];

    fetch_controller #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .RESET_PC (8'h00),
        .LONG_BIT (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] irpc, input logic [7:0] op, input logic [7:0] pc);
        exp_t e;
        e.ir_pc   = irpc;
        e.operand = op;
        e.pc      = pc;
        sb_q.push_back(e);
    endtask

    // Monitor: each new presentation of ir_valid consumes one expectation.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ir_valid === 1'b1 && prev_valid !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_ir_pc", {24'd0, bus.ir_pc}, {24'd0, e.ir_pc});
                    chk("sb_operand", {24'd0, bus.operand}, {24'd0, e.operand});
                    chk("sb_pc", {24'd0, bus.address}, {24'd0, e.pc});
                end
            end
            prev_valid = bus.ir_valid;
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h12;
        mem[8'h05] = 8'h83;
        mem[8'h06] = 8'h2A;
        mem[8'h07] = 8'h9C;
        mem[8'h08] = 8'h77;
        mem[8'hFF] = 8'hA1;
        mem[8'h40] = 8'h05;
        mem[8'h41] = 8'h33;

        rst           = 1'b1;
        bus.stall     = 1'b0;
        bus.halt      = 1'b0;
        bus.pc_load   = 1'b0;
        bus.pc_target = 8'h00;
        bus.instr_ack = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_address", {24'd0, bus.address}, 32'h00);
        chk("rst_memread", {31'd0, bus.memread}, 32'd0);
        chk("rst_irwrite", {31'd0, bus.irwrite}, 32'd0);
        chk("rst_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_operand", {24'd0, bus.operand}, 32'h00);
        chk("rst_ir_pc", {24'd0, bus.ir_pc}, 32'h00);

        // Short instruction from reset: IDLE, FETCH, VALID on the 3rd cycle
        push(8'h00, 8'h00, 8'h01);
        rst = 1'b0;
        tick();
        chk("s1_fetch_addr", {24'd0, bus.address}, 32'h00);
        chk("s1_fetch_memread", {31'd0, bus.memread}, 32'd1);
        chk("s1_fetch_irwrite", {31'd0, bus.irwrite}, 32'd1);
        chk("s1_fetch_not_valid", {31'd0, bus.ir_valid}, 32'd0);
        tick();
        chk("s1_valid", {31'd0, bus.ir_valid}, 32'd1);
        chk("s1_valid_memread", {31'd0, bus.memread}, 32'd0);

        // Long instruction at 05 via redirect
        bus.pc_load   = 1'b1;
        bus.pc_target = 8'h05;
        tick();
        bus.pc_load = 1'b0;
        push(8'h05, 8'h2A, 8'h07);
        #1;
        chk("l_fetch_addr", {24'd0, bus.address}, 32'h05);
        chk("l_fetch_valid_drop", {31'd0, bus.ir_valid}, 32'd0);
        chk("l_fetch_irwrite", {31'd0, bus.irwrite}, 32'd1);
        tick();
        chk("l_oper_addr", {24'd0, bus.address}, 32'h06);
        chk("l_oper_memread", {31'd0, bus.memread}, 32'd1);
        chk("l_oper_irwrite", {31'd0, bus.irwrite}, 32'd0);
        chk("l_oper_not_valid", {31'd0, bus.ir_valid}, 32'd0);
        tick();
        chk("l_valid", {31'd0, bus.ir_valid}, 32'd1);

        // Ack, then long opcode at 07 with a 3-cycle stall in OPERAND
        bus.instr_ack = 1'b1;
        tick();
        bus.instr_ack = 1'b0;
        push(8'h07, 8'h77, 8'h09);
        #1;
        chk("st_fetch_addr", {24'd0, bus.address}, 32'h07);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_memread", {31'd0, bus.memread}, 32'd0);
            chk("st_irwrite", {31'd0, bus.irwrite}, 32'd0);
            chk("st_addr", {24'd0, bus.address}, 32'h08);
            tick();
        end
        chk("st_operand_frozen", {24'd0, bus.operand}, 32'h2A);
        chk("st_not_valid", {31'd0, bus.ir_valid}, 32'd0);
        bus.stall = 1'b0;
        #1;
        chk("st_resume_memread", {31'd0, bus.memread}, 32'd1);
        tick();
        chk("st_valid", {31'd0, bus.ir_valid}, 32'd1);

        // Long opcode at FF: operand from 00, pc wraps to 01
        mem[8'h00] = 8'h55;
        bus.pc_load   = 1'b1;
        bus.pc_target = 8'hFF;
        tick();
        bus.pc_load = 1'b0;
        push(8'hFF, 8'h55, 8'h01);
        tick();
        chk("w_oper_addr", {24'd0, bus.address}, 32'h00);
        tick();
        chk("w_valid", {31'd0, bus.ir_valid}, 32'd1);

        // instr_ack and pc_load together: redirect wins
        bus.instr_ack = 1'b1;
        bus.pc_load   = 1'b1;
        bus.pc_target = 8'h40;
        #1;
        chk("pl_irwrite", {31'd0, bus.irwrite}, 32'd0);
        tick();
        bus.instr_ack = 1'b0;
        bus.pc_load   = 1'b0;
        push(8'h40, 8'h55, 8'h41);
        #1;
        chk("pl_addr", {24'd0, bus.address}, 32'h40);
        chk("pl_valid_drop", {31'd0, bus.ir_valid}, 32'd0);
        chk("pl_memread", {31'd0, bus.memread}, 32'd1);
        tick();
        chk("pl_short_valid", {31'd0, bus.ir_valid}, 32'd1);

        // halt during FETCH, sticky until rst
        bus.instr_ack = 1'b1;
        tick();
        bus.instr_ack = 1'b0;
        bus.halt      = 1'b1;
        #1;
        chk("h_irwrite", {31'd0, bus.irwrite}, 32'd0);
        chk("h_memread", {31'd0, bus.memread}, 32'd0);
        tick();
        bus.halt = 1'b0;
        chk("h_halted", {31'd0, bus.halted}, 32'd1);
        chk("h_addr", {24'd0, bus.address}, 32'h41);
        chk("h_not_valid", {31'd0, bus.ir_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.instr_ack = (i % 2 == 0);
            bus.pc_load   = (i % 2 == 1);
            bus.pc_target = 8'h80;
            tick();
            chk("h_sticky", {31'd0, bus.halted}, 32'd1);
            chk("h_sticky_addr", {24'd0, bus.address}, 32'h41);
            chk("h_sticky_memread", {31'd0, bus.memread}, 32'd0);
        end
        bus.instr_ack = 1'b0;
        bus.pc_load   = 1'b0;
        rst = 1'b1;
        tick();
        chk("hr_addr", {24'd0, bus.address}, 32'h00);
        chk("hr_halted", {31'd0, bus.halted}, 32'd0);
        chk("hr_ir_valid", {31'd0, bus.ir_valid}, 32'd0);
        chk("hr_operand", {24'd0, bus.operand}, 32'h00);
        chk("hr_ir_pc", {24'd0, bus.ir_pc}, 32'h00);
        rst = 1'b0;
        tick();
        chk("hr_fetch_memread", {31'd0, bus.memread}, 32'd1);

        // rst while in FETCH keeps memread low
        rst = 1'b1;
        #1;
        chk("rst_fetch_memread", {31'd0, bus.memread}, 32'd0);
        tick();
        rst = 1'b0;

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_controller

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Front-end sequencer of the 8-bit multi-cycle CPU, directly upstream of instruction_memory / instruction_register.
- Owns the program counter (PC) and runs a fetch FSM that drives address, memread and irwrite.
- Detects two-byte (opcode + immediate) instructions and captures the operand byte.
- Presents a valid/ack handshake to the decode/control stage and accepts PC redirects from execute.

Parameters:
- ADDR_W, 8, PC / memory address width
- DATA_W, 8, instruction byte width
- RESET_PC, 8'h00, PC value loaded on reset
- LONG_BIT, 7, opcode bit index; 1 marks a two-byte instruction

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_byte  in  DATA_W  byte from instruction memory (combinational read of address)
- stall  in  1  freeze fetch this cycle
- halt  in  1  enter HALTED (sticky until rst)
- pc_load  in  1  redirect PC (branch/jump taken)
- pc_target  in  ADDR_W  redirect address
- instr_ack  in  1  decode has consumed the current instruction
- address  out  ADDR_W  memory address (= PC)
- memread  out  1  memory read enable
- irwrite  out  1  instruction register load strobe
- operand  out  DATA_W  immediate byte of a two-byte instruction
- ir_pc  out  ADDR_W  address of the opcode byte now held in the IR
- ir_valid  out  1  IR/operand hold a complete instruction
- halted  out  1  FSM is in HALTED

Behaviour:
- One clock; reset is synchronous and active-high, all state updates on posedge clk.
- Reset: pc=RESET_PC; state=IDLE; operand=0; ir_pc=0; ir_valid=0; halted=0; memread=0; irwrite=0.
- address = pc at all times.
- memread and irwrite are combinational from state and inputs, and never asserted in reset.
- FSM states:
  - IDLE: one cycle, no memory access, then FETCH.
  - FETCH: memread=1, irwrite=1.
    - At the edge: IR captures instr_byte, ir_pc<=pc, pc<=pc+1.
    - Next state is OPERAND if instr_byte[LONG_BIT]=1, else VALID.
  - OPERAND: memread=1, irwrite=0. At the edge: operand<=instr_byte, pc<=pc+1, next state VALID.
  - VALID: ir_valid=1, memread=0. On instr_ack: next state FETCH; otherwise hold.
  - HALTED: halted=1, memread=0, ir_valid=0. Exits only on rst.
- Short instructions do not modify operand (previous value retained).
- Priority per cycle: rst > halt > pc_load > stall > normal transition.
  - halt in any state: next state HALTED; irwrite/memread forced 0 that cycle; pc unchanged.
  - pc_load in any non-HALTED state:
    - pc<=pc_target, next state FETCH, ir_valid drops next cycle.
    - irwrite forced 0 that cycle, so a partially fetched instruction is discarded.
    - Takes priority over a simultaneous instr_ack.
  - stall: state, pc and operand hold; memread=0, irwrite=0. ir_valid keeps its value; instr_ack during stall is ignored.
  - instr_ack outside VALID is ignored.
- Arithmetic: pc increments modulo 2^ADDR_W. 8'hFF+1 = 8'h00.
  - A long opcode at 8'hFF fetches its operand from 8'h00.
- Latency, no stalls:
  - Reset release to ir_valid: 3 cycles for a short instruction, 4 for a long one.
  - instr_ack to next ir_valid: 2 cycles (short) / 3 cycles (long).
- rst asserted mid-operation (any state) returns all outputs to reset values on the next edge.

Decomposition:
- cpu_pkg holds:
  - ADDR_W/DATA_W constants.
  - Fetch state encoding: IDLE=3'd0, FETCH=3'd1, OPERAND=3'd2, VALID=3'd3, HALTED=3'd4.
  - LONG_BIT definition, shared with the decoder.
- One sub-module: program_counter, with load / increment / hold and synchronous reset to RESET_PC.
- The FSM stays in fetch_controller.

Test Plan:
- Reset release, memory[0]=8'h12 (short) -> IDLE, FETCH (address=00, memread=1, irwrite=1), then ir_valid=1 with ir_pc=00, pc=01 on the 3rd cycle.
- memory[5]=8'h83, memory[6]=8'h2A, PC=05 -> FETCH then OPERAND, operand=8'h2A, ir_pc=05, pc=07, ir_valid on the 4th cycle after start.
- Long opcode at 8'hFF with memory[00]=8'h55 -> operand=8'h55, pc wraps to 8'h01.
- In VALID, assert instr_ack and pc_load with pc_target=8'h40 in the same cycle -> next state FETCH, address=8'h40, ir_valid=0.
- stall held 3 cycles during OPERAND -> pc, state and operand frozen, memread=0. Fetch completes 3 cycles late with the correct operand.
- halt during FETCH -> irwrite=0 that cycle, halted=1 persists while instr_ack/pc_load toggle; rst -> pc=RESET_PC, state IDLE.
